// File: rtl/banco_registros_sb.sv
// banco_registros_sb: parametrised 2-read/1-write register file with
// write-to-read bypass, an optional hardwired-zero register and a
// per-register pending-write scoreboard for RAW hazard detection.
//
// Ports:
//   CLK, RST          clock, synchronous active-low reset
//   Add_A/Add_B       read addresses
//   Info_A/Info_B     read data (combinational, bypassed when enabled)
//   Busy_A/Busy_B     pending-write flag of the addressed register (comb.)
//   Issue_En/Dest     mark a destination register as pending
//   Write_En/Add_Dest/Write_Data  write-back port
//   Flush             drop every pending bit
//   Pending_Cnt       registered number of pending registers
module banco_registros_sb #(
    parameter int unsigned DATA_W   = 32,
    parameter int unsigned ADDR_W   = 5,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] Add_A,
    input  logic [ADDR_W-1:0] Add_B,
    output logic [DATA_W-1:0] Info_A,
    output logic [DATA_W-1:0] Info_B,
    output logic              Busy_A,
    output logic              Busy_B,
    input  logic              Issue_En,
    input  logic [ADDR_W-1:0] Issue_Dest,
    input  logic              Write_En,
    input  logic [ADDR_W-1:0] Add_Dest,
    input  logic [DATA_W-1:0] Write_Data,
    input  logic              Flush,
    output logic [ADDR_W:0]   Pending_Cnt
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned CNT_W = ADDR_W + 1;

    logic [DATA_W-1:0] regs [DEPTH];
    logic [DEPTH-1:0]  pending;
    logic [DEPTH-1:0]  pending_next;
    logic [CNT_W-1:0]  cnt_next;
    logic              bypass_a;
    logic              bypass_b;

    // Register 0 is read-only when the hardwired-zero option is on.
    function automatic logic writable(input logic [ADDR_W-1:0] a);
        return !((ZERO_REG != 0) && (a == '0));
    endfunction

    // Same-cycle write-back hitting a read port.
    always_comb begin
        bypass_a = (BYPASS != 0) && Write_En && (Add_Dest == Add_A) && writable(Add_A);
        bypass_b = (BYPASS != 0) && Write_En && (Add_Dest == Add_B) && writable(Add_B);
    end

    // Read ports: zero register, then bypass, then stored value.
    always_comb begin
        Info_A = regs[Add_A];
        Info_B = regs[Add_B];
        if (!writable(Add_A)) begin
            Info_A = '0;
        end else if (bypass_a) begin
            Info_A = Write_Data;
        end
        if (!writable(Add_B)) begin
            Info_B = '0;
        end else if (bypass_b) begin
            Info_B = Write_Data;
        end
    end

    // A register being written this cycle is reported ready under bypass.
    always_comb begin
        Busy_A = pending[Add_A] && !bypass_a;
        Busy_B = pending[Add_B] && !bypass_b;
    end

    // Scoreboard update: write-back clears, a newer issue re-sets, flush wins.
    always_comb begin
        pending_next = pending;
        if (Write_En) begin
            pending_next[Add_Dest] = 1'b0;
        end
        if (Issue_En && writable(Issue_Dest)) begin
            pending_next[Issue_Dest] = 1'b1;
        end
        if (Flush) begin
            pending_next = '0;
        end
    end

    // Popcount of the post-edge scoreboard, registered alongside it.
    always_comb begin
        cnt_next = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            cnt_next = cnt_next + CNT_W'(pending_next[i]);
        end
    end

    // State: register contents, scoreboard and pending count.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
            pending     <= '0;
            Pending_Cnt <= '0;
        end else begin
            if (Write_En && writable(Add_Dest)) begin
                regs[Add_Dest] <= Write_Data;
            end
            pending     <= pending_next;
            Pending_Cnt <= cnt_next;
        end
    end

endmodule
